wb_result_pipe: RTL and testbench



---
 rtl/wb_result_pipe_if.sv | 31 +++
 rtl/wb_result_pipe.sv | 112 +++++++++++
 tb/tb_wb_result_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_result_pipe_if.sv
// Bus between the execution-unit result mux and the write-back staging pipe:
// one result packet plus flush in, staged slots, write-back packet and error flags out.
interface wb_result_pipe_if #(
  parameter int DEPTH = 7,
  parameter int PKT_W = 143
);
  logic             flush;
  logic [0:PKT_W-1] in_pkt;
  logic [0:PKT_W-1] wrt_back_arr;
  logic [0:PKT_W-1] fwd_pkt [DEPTH];
  logic             lat_err;
  logic             coll_err;

  modport master (
    output flush,
    output in_pkt,
    input  wrt_back_arr,
    input  fwd_pkt,
    input  lat_err,
    input  coll_err
  );

  modport slave (
    input  flush,
    input  in_pkt,
    output wrt_back_arr,
    output fwd_pkt,
    output lat_err,
    output coll_err
  );
endinterface

// File: rtl/wb_result_pipe.sv
// Result staging shift register: each finished packet is dropped into the slot
// matching its unit latency so every instruction writes back in order from the last slot.
module wb_result_pipe #(
  parameter int DEPTH        = 7,
  parameter int PKT_W        = 143,
  parameter int FLUSH_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  wb_result_pipe_if.slave bus
);

  localparam int VLD_B = 131;
  localparam int LAT_B = 139;
  localparam int LAT_W = 4;

  typedef logic [0:PKT_W-1] pkt_t;

  localparam pkt_t             PKT_ZERO = {PKT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(DEPTH);

  function automatic logic pkt_valid(input pkt_t p);
    return p[VLD_B];
  endfunction

  function automatic logic [LAT_W-1:0] pkt_lat(input pkt_t p);
    return p[LAT_B:LAT_B+LAT_W-1];
  endfunction

  // Flush kills only the write enable; data, address and latency stay visible.
  function automatic pkt_t pkt_kill(input pkt_t p);
    pkt_t q;
    q        = p;
    q[VLD_B] = 1'b0;
    return q;
  endfunction

  pkt_t             r_slot [DEPTH];
  logic             r_lat_err;
  logic             r_coll_err;

  pkt_t             w_shift [DEPTH];
  pkt_t             w_next  [DEPTH];
  pkt_t             w_cand;
  logic [LAT_W-1:0] w_lat;
  logic             w_legal;
  logic             w_ins;
  logic             w_bad;
  logic             w_coll;

  // Decode the incoming packet's write enable and latency.
  always_comb begin
    w_lat   = pkt_lat(bus.in_pkt);
    w_legal = (w_lat != 4'd0) && (w_lat <= LAT_MAX);
    w_ins   = pkt_valid(bus.in_pkt) && w_legal;
    w_bad   = pkt_valid(bus.in_pkt) && !w_legal;
  end

  // Shift every slot one step toward write-back; a bubble enters slot 0.
  always_comb begin
    w_shift[0] = PKT_ZERO;
    for (int i = 1; i < DEPTH; i++) begin
      w_shift[i] = r_slot[i-1];
    end
  end

  // Overlay the insertion on the shifted slots, then apply the young-slot flush.
  // Collision is judged on the shifted value before flush can clear it.
  always_comb begin
    w_coll = 1'b0;
    w_cand = PKT_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ins && (w_lat == LAT_W'(i + 1))) begin
        w_coll = pkt_valid(w_shift[i]);
        w_cand = bus.in_pkt;
      end else begin
        w_cand = w_shift[i];
      end
      if (bus.flush && (i < FLUSH_STAGES)) begin
        w_next[i] = pkt_kill(w_cand);
      end else begin
        w_next[i] = w_cand;
      end
    end
  end

  // Slot registers and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= PKT_ZERO;
      end
      r_lat_err  <= 1'b0;
      r_coll_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= w_next[i];
      end
      r_lat_err  <= r_lat_err | w_bad;
      r_coll_err <= r_coll_err | w_coll;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
    assign bus.fwd_pkt[g] = r_slot[g];
  end

  assign bus.wrt_back_arr = r_slot[DEPTH-1];
  assign bus.lat_err      = r_lat_err;
  assign bus.coll_err     = r_coll_err;

endmodule

// File: tb/tb_wb_result_pipe.sv
// Self-checking bench for wb_result_pipe: directed scenarios followed by random traffic,
// checked against a model that tracks each packet by the edge on which it must write back.
module tb_wb_result_pipe;

  localparam int DEPTH        = 7;
  localparam int PKT_W        = 143;
  localparam int FLUSH_STAGES = 2;

  typedef logic [0:PKT_W-1] pkt_t;

  logic clock = 1'b0;
  logic reset;

  wb_result_pipe_if #(.DEPTH(DEPTH), .PKT_W(PKT_W)) bus ();

  wb_result_pipe #(
    .DEPTH       (DEPTH),
    .PKT_W       (PKT_W),
    .FLUSH_STAGES(FLUSH_STAGES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;
  pkt_t exp_wb [int];
  logic m_lat_err  = 1'b0;
  logic m_coll_err = 1'b0;
  pkt_t idle_pkt   = {PKT_W{1'b0}};

  task automatic check_val(input string tag, input logic [PKT_W-1:0] obs,
                           input logic [PKT_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [2:0] unit, input logic [127:0] data,
                              input logic we, input logic [6:0] rt, input logic [3:0] lat);
    return {unit, data, we, rt, lat};
  endfunction

  function automatic pkt_t rnd_data_pkt(input logic we, input logic [3:0] lat);
    return mk(3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
              we, 7'($urandom_range(0, 127)), lat);
  endfunction

  // Model: a packet inserted on edge n with latency L writes back on edge n+DEPTH-L;
  // after edge n, slot s holds the packet due on edge n+DEPTH-1-s.
  task automatic model_edge(input pkt_t p, input logic fl, input logic rs);
    int   lat;
    int   e;
    pkt_t t;
    edge_n++;
    if (rs) begin
      exp_wb.delete();
      m_lat_err  = 1'b0;
      m_coll_err = 1'b0;
    end else begin
      lat = int'(p[139:142]);
      if (p[131]) begin
        if (lat < 1 || lat > DEPTH) begin
          m_lat_err = 1'b1;
        end else begin
          e = edge_n + DEPTH - lat;
          if (exp_wb.exists(e)) begin
            t = exp_wb[e];
            if (t[131]) m_coll_err = 1'b1;
          end
          exp_wb[e] = p;
        end
      end
      if (fl) begin
        for (int s = 0; s < FLUSH_STAGES; s++) begin
          e = edge_n + DEPTH - 1 - s;
          if (exp_wb.exists(e)) begin
            t         = exp_wb[e];
            t[131]    = 1'b0;
            exp_wb[e] = t;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int   e;
    pkt_t x;
    for (int s = 0; s < DEPTH; s++) begin
      e = edge_n + DEPTH - 1 - s;
      x = exp_wb.exists(e) ? exp_wb[e] : idle_pkt;
      check_val($sformatf("fwd%0d@%0d", s, edge_n), bus.fwd_pkt[s], x);
      if (s == DEPTH - 1) check_val($sformatf("wb@%0d", edge_n), bus.wrt_back_arr, x);
    end
    check_val($sformatf("lat_err@%0d", edge_n), bus.lat_err, m_lat_err);
    check_val($sformatf("coll_err@%0d", edge_n), bus.coll_err, m_coll_err);
  endtask

  task automatic tick(input pkt_t p, input logic fl, input logic rs);
    bus.in_pkt = p;
    bus.flush  = fl;
    reset      = rs;
    @(posedge clock);
    model_edge(p, fl, rs);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(idle_pkt, 1'b0, 1'b0);
  endtask

  pkt_t p_a, p_b, p_c, p_d, killed;

  initial begin
    bus.in_pkt = idle_pkt;
    bus.flush  = 1'b0;
    reset      = 1'b1;

    // Reset held two cycles with a valid L=3 packet presented; it must never surface.
    p_a = mk(3'd1, {4{32'h1234_5678}}, 1'b1, 7'd9, 4'd3);
    tick(p_a, 1'b0, 1'b1);
    tick(p_a, 1'b0, 1'b1);
    check_val("rst_wb", bus.wrt_back_arr, idle_pkt);
    idle(DEPTH + 1);

    // Single L=2 packet: slot 1 next edge, write-back five edges later, gone after.
    p_a = mk(3'd2, {16{8'hA5}}, 1'b1, 7'd5, 4'd2);
    tick(p_a, 1'b0, 1'b0);
    check_val("single_fwd1", bus.fwd_pkt[1], p_a);
    idle(5);
    check_val("single_wb", bus.wrt_back_arr, p_a);
    check_val("single_we", bus.wrt_back_arr[131], 1'b1);
    check_val("single_rt", bus.wrt_back_arr[132:138], 7'd5);
    idle(1);
    check_val("single_gone", bus.wrt_back_arr, idle_pkt);
    idle(2);

    // L=2 then L=7: the younger long-latency op is older in write-back order.
    p_a = rnd_data_pkt(1'b1, 4'd2);
    p_b = rnd_data_pkt(1'b1, 4'd7);
    tick(p_a, 1'b0, 1'b0);
    tick(p_b, 1'b0, 1'b0);
    check_val("order_l7", bus.wrt_back_arr, p_b);
    idle(4);
    check_val("order_l2", bus.wrt_back_arr, p_a);
    check_val("order_nocoll", bus.coll_err, 1'b0);
    idle(2);

    // Collision: L=2 then L=3 both target slot 2 on the second edge.
    tick(idle_pkt, 1'b0, 1'b1);
    p_a = rnd_data_pkt(1'b1, 4'd2);
    p_b = rnd_data_pkt(1'b1, 4'd3);
    tick(p_a, 1'b0, 1'b0);
    tick(p_b, 1'b0, 1'b0);
    check_val("coll_flag", bus.coll_err, 1'b1);
    idle(4);
    check_val("coll_winner", bus.wrt_back_arr, p_b);
    idle(3);
    check_val("coll_sticky", bus.coll_err, 1'b1);

    // Flush: L=4 survives; L=2 and L=1 leave with write enable cleared, data intact.
    tick(idle_pkt, 1'b0, 1'b1);
    p_a = rnd_data_pkt(1'b1, 4'd4);
    p_b = rnd_data_pkt(1'b1, 4'd2);
    p_c = rnd_data_pkt(1'b1, 4'd1);
    tick(p_a, 1'b0, 1'b0);
    tick(p_b, 1'b1, 1'b0);
    tick(p_c, 1'b1, 1'b0);
    idle(1);
    check_val("flush_l4_wb", bus.wrt_back_arr, p_a);
    check_val("flush_l4_we", bus.wrt_back_arr[131], 1'b1);
    idle(3);
    check_val("flush_l2_we", bus.wrt_back_arr[131], 1'b0);
    check_val("flush_l2_data", bus.wrt_back_arr[3:130], p_b[3:130]);
    idle(2);
    killed      = p_c;
    killed[131] = 1'b0;
    check_val("flush_l1_pkt", bus.wrt_back_arr, killed);
    check_val("flush_nocoll", bus.coll_err, 1'b0);

    // Illegal latencies 0 and 9 are dropped and latch lat_err until reset.
    tick(idle_pkt, 1'b0, 1'b1);
    p_a = rnd_data_pkt(1'b1, 4'd0);
    p_b = rnd_data_pkt(1'b1, 4'd9);
    tick(p_a, 1'b0, 1'b0);
    check_val("lat0_flag", bus.lat_err, 1'b1);
    check_val("lat0_slot0", bus.fwd_pkt[0], idle_pkt);
    tick(p_b, 1'b0, 1'b0);
    idle(DEPTH);
    check_val("lat_sticky", bus.lat_err, 1'b1);
    check_val("lat_wb", bus.wrt_back_arr, idle_pkt);
    tick(idle_pkt, 1'b0, 1'b1);
    check_val("lat_clear", bus.lat_err, 1'b0);

    // Random traffic: mixed latencies, occasional illegal latency, flush and reset.
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] lat;
      if ($urandom_range(0, 99) < 90) lat = 4'($urandom_range(1, DEPTH));
      else                            lat = 4'($urandom_range(0, 15));
      p_d = rnd_data_pkt(($urandom_range(0, 99) < 60), lat);
      tick(p_d, ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
